// File: rtl/wb_queue_32bit.sv
// Writeback queue between the ALU/load units and the register file.
// Buffers results in a small FIFO, drains one per cycle and flags pending destination registers.
module wb_queue_32bit #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [RWIDTH-1:0]          alu_wa,
  input  logic [DWIDTH-1:0]          alu_wd,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [RWIDTH-1:0]          mem_wa,
  input  logic [DWIDTH-1:0]          mem_wd,
  input  logic                       wb_stall,
  output logic [RWIDTH-1:0]          wa,
  output logic [DWIDTH-1:0]          wd,
  output logic                       we,
  input  logic [RWIDTH-1:0]          pend_ra1,
  input  logic [RWIDTH-1:0]          pend_ra2,
  output logic                       pend_hit1,
  output logic                       pend_hit2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [RWIDTH-1:0] ent_wa_q [DEPTH];
  logic [RWIDTH-1:0] ent_wa_d [DEPTH];
  logic [DWIDTH-1:0] ent_wd_q [DEPTH];
  logic [DWIDTH-1:0] ent_wd_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push_fire;
  logic              push_en;
  logic              pop;
  logic [RWIDTH-1:0] push_wa;
  logic [DWIDTH-1:0] push_wd;

  // Readiness looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign count     = count_q;

  assign we  = !empty && !wb_stall;
  assign pop = we;
  assign wa  = ent_wa_q[rd_ptr_q];
  assign wd  = ent_wd_q[rd_ptr_q];

  always_comb begin
    push_fire = 1'b0;
    push_wa   = alu_wa;
    push_wd   = alu_wd;
    if (mem_valid && mem_ready) begin
      push_fire = 1'b1;
      push_wa   = mem_wa;
      push_wd   = mem_wd;
    end else if (alu_valid && alu_ready) begin
      push_fire = 1'b1;
    end
  end

  // Writes to r0 complete their handshake but are discarded here.
  assign push_en = push_fire && (push_wa != '0);

  always_comb begin
    ent_wa_d = ent_wa_q;
    ent_wd_d = ent_wd_q;
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end
    if (push_en) begin
      ent_wa_d[wr_ptr_q] = push_wa;
      ent_wd_d[wr_ptr_q] = push_wd;
      vld_d[wr_ptr_q]    = 1'b1;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    case ({push_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ent_wa_q <= ent_wa_d;
      ent_wd_q <= ent_wd_d;
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // The head entry keeps reporting a hit until it has actually left the queue.
  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (ent_wa_q[i] == pend_ra1)) pend_hit1 = 1'b1;
      if (vld_q[i] && (ent_wa_q[i] == pend_ra2)) pend_hit2 = 1'b1;
    end
    if (pend_ra1 == '0) pend_hit1 = 1'b0;
    if (pend_ra2 == '0) pend_hit2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_queue_32bit.sv
// Bench for wb_queue_32bit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_queue_32bit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, wb_stall;
  logic        alu_ready, mem_ready;
  logic [5:0]  alu_wa, mem_wa, pend_ra1, pend_ra2, wa;
  logic [31:0] alu_wd, mem_wd, wd;
  logic        we, pend_hit1, pend_hit2, full, empty;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  wa;
    logic [31:0] wd;
  } entry_t;

  entry_t mq[$];
  bit     model_on = 1'b0;

  wb_queue_32bit #(.RWIDTH(6), .DWIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wa(alu_wa), .alu_wd(alu_wd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_stall(wb_stall), .wa(wa), .wd(wd), .we(we),
    .pend_ra1(pend_ra1), .pend_ra2(pend_ra2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic mv, input logic [5:0] mwa, input logic [31:0] mwd,
                               input logic av, input logic [5:0] awa, input logic [31:0] awd,
                               input logic stall);
    mem_valid = mv;  mem_wa = mwa;  mem_wd = mwd;
    alu_valid = av;  alu_wa = awa;  alu_wd = awd;
    wb_stall  = stall;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit(input logic [5:0] ra);
    if (ra == 6'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].wa == ra) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model advances on each rising edge from the inputs held across it.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      model_on <= 1'b1;
    end else if (model_on) begin
      bit     do_pop;
      bit     acc_mem;
      bit     acc_alu;
      entry_t e;
      do_pop  = (mq.size() > 0) && !wb_stall;
      acc_mem = mem_valid && (mq.size() < DEPTH);
      acc_alu = !mem_valid && alu_valid && (mq.size() < DEPTH);
      if (do_pop) void'(mq.pop_front());
      if (acc_mem && mem_wa != 6'd0) begin
        e.wa = mem_wa; e.wd = mem_wd; mq.push_back(e);
      end else if (acc_alu && alu_wa != 6'd0) begin
        e.wa = alu_wa; e.wd = alu_wd; mq.push_back(e);
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (model_on && !rst) begin
      logic exp_we;
      exp_we = (mq.size() > 0) && !wb_stall;
      checkOutput("m_count", 32'(count), 32'(mq.size()));
      checkOutput("m_empty", 32'(empty), 32'(mq.size() == 0));
      checkOutput("m_full", 32'(full), 32'(mq.size() == DEPTH));
      checkOutput("m_mem_ready", 32'(mem_ready), 32'(mq.size() != DEPTH));
      checkOutput("m_alu_ready", 32'(alu_ready), 32'((mq.size() != DEPTH) && !mem_valid));
      checkOutput("m_we", 32'(we), 32'(exp_we));
      if (exp_we) begin
        checkOutput("m_wa", 32'(wa), 32'(mq[0].wa));
        checkOutput("m_wd", wd, mq[0].wd);
      end
      checkOutput("m_hit1", 32'(pend_hit1), 32'(model_hit(pend_ra1)));
      checkOutput("m_hit2", 32'(pend_hit2), 32'(model_hit(pend_ra2)));
    end
  end

  initial begin
    rst = 1'b1;
    pend_ra1 = 6'd0;
    pend_ra2 = 6'd0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset for two cycles then idle
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_we", 32'(we), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_alu_ready", 32'(alu_ready), 1);
    checkOutput("rst_mem_ready", 32'(mem_ready), 1);
    checkOutput("rst_hit1", 32'(pend_hit1), 0);

    // Single ALU write with one-cycle latency
    applyStimulus(0, 0, 0, 1, 6'd5, 32'hDEADBEEF, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("lat_we", 32'(we), 1);
    checkOutput("lat_wa", 32'(wa), 5);
    checkOutput("lat_wd", wd, 32'hDEADBEEF);
    checkOutput("lat_count", 32'(count), 1);
    tick();
    @(negedge clk);
    checkOutput("lat_count_after", 32'(count), 0);
    checkOutput("lat_we_after", 32'(we), 0);

    // Fill under stall, then drain in order
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(0, 0, 0, 1, 6'(r), 32'h100 + 32'(r), 1);
      tick();
    end
    applyStimulus(0, 0, 0, 1, 6'd5, 32'h105, 1);
    @(negedge clk);
    checkOutput("fill_full", 32'(full), 1);
    checkOutput("fill_alu_ready", 32'(alu_ready), 0);
    checkOutput("fill_count", 32'(count), 4);
    checkOutput("fill_we", 32'(we), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      checkOutput("drain_we", 32'(we), 1);
      checkOutput("drain_wa", 32'(wa), 32'(r));
      checkOutput("drain_wd", wd, 32'h100 + 32'(r));
      tick();
    end
    @(negedge clk);
    checkOutput("drain_empty", 32'(empty), 1);

    // Load beats ALU in the same cycle
    applyStimulus(1, 6'd7, 32'd1, 1, 6'd8, 32'd2, 0);
    @(negedge clk);
    checkOutput("prio_alu_ready", 32'(alu_ready), 0);
    checkOutput("prio_mem_ready", 32'(mem_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 1, 6'd8, 32'd2, 0);
    @(negedge clk);
    checkOutput("prio_alu_ready2", 32'(alu_ready), 1);
    checkOutput("prio_wa7", 32'(wa), 7);
    checkOutput("prio_wd7", wd, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("prio_count_pushpop", 32'(count), 1);
    checkOutput("prio_wa8", 32'(wa), 8);
    checkOutput("prio_wd8", wd, 2);
    tick();

    // r0 write is accepted but dropped
    applyStimulus(0, 0, 0, 1, 6'd0, 32'hFFFFFFFF, 0);
    @(negedge clk);
    checkOutput("r0_alu_ready", 32'(alu_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("r0_count", 32'(count), 0);
    checkOutput("r0_we", 32'(we), 0);
    tick();

    // Same register twice: FIFO order, last wins
    applyStimulus(0, 0, 0, 1, 6'd3, 32'hAAAA, 1);
    tick();
    applyStimulus(1, 6'd3, 32'hBBBB, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("dup_wd_first", wd, 32'hAAAA);
    tick();
    @(negedge clk);
    checkOutput("dup_wd_second", wd, 32'hBBBB);
    tick();

    // Pending hazard then reset drops it
    applyStimulus(0, 0, 0, 1, 6'd9, 32'h99, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    pend_ra1 = 6'd9;
    pend_ra2 = 6'd0;
    @(negedge clk);
    checkOutput("pend_hit1", 32'(pend_hit1), 1);
    checkOutput("pend_hit2_r0", 32'(pend_hit2), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("pend_rst_hit1", 32'(pend_hit1), 0);
    checkOutput("pend_rst_count", 32'(count), 0);
    checkOutput("pend_rst_we", 32'(we), 0);

    // Reset while draining must suppress the following write
    applyStimulus(0, 0, 0, 1, 6'd12, 32'h12, 1);
    tick(); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_we", 32'(we), 0);
    tick();

    // Mixed traffic checked purely by the model
    for (int c = 0; c < 300; c++) begin
      applyStimulus(1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 2) == 0));
      pend_ra1 = 6'($urandom_range(0, 7));
      pend_ra2 = 6'($urandom_range(0, 7));
      rst = ($urandom_range(0, 60) == 0);
      tick();
    end
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
